// File: rtl/wrr_pkt_arbiter.sv
// wrr_pkt_arbiter: two-input, packet-granular weighted round-robin merge with FWFT input FIFOs.
// Define PKT_ARB_STATS_EN to add the per-input forwarded-packet counters pkt_cnt0/pkt_cnt1.

module small_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 5,
  parameter int PROG_FULL_THRESHOLD = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int MAX_DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   DEPTH_MAX = (MAX_DEPTH_BITS + 1)'(MAX_DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   DEPTH_NF  = (MAX_DEPTH_BITS + 1)'(PROG_FULL_THRESHOLD);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = 1;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = 1;

  logic [WIDTH-1:0]          mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;

  assign full        = (depth == DEPTH_MAX);
  assign empty       = (depth == '0);
  assign nearly_full = (depth >= DEPTH_NF);
  assign do_rd       = rd_en && !empty;
  assign do_wr       = wr_en && !full;

  // First-word-fall-through: the head entry is always visible on dout.
  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + CNT_ONE;
        2'b01:   depth <= depth - CNT_ONE;
        default: depth <= depth;
      endcase
    end
  end
endmodule

// state | meaning
// IDLE  | between packets; first word may come from either input
// HDR   | module-header words of the granted packet
// BODY  | body words; next ctrl!=0 word is EOP
module wrr_pkt_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int WEIGHT0    = 1,
  parameter int WEIGHT1    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1
`endif
);
  localparam int FW = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [7:0] WEIGHT0_L = 8'(WEIGHT0);
  localparam logic [7:0] WEIGHT1_L = 8'(WEIGHT1);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t        state;
  logic          gnt;
  logic [7:0]    cnt;
  logic          sel;
  logic [1:0]    empty;
  logic [1:0]    nearly_full;
  logic [1:0]    rd_en;
  logic [FW-1:0] fifo_dout [2];
  logic          ctrl_nz;
  logic          eop;
  logic [7:0]    weight;
  logic [8:0]    cnt_next;
  logic          credit_done;

  small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(5), .PROG_FULL_THRESHOLD(31)) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .din         ({in0_ctrl, in0_data}),
    .wr_en       (in0_wr),
    .rd_en       (rd_en[0]),
    .dout        (fifo_dout[0]),
    .nearly_full (nearly_full[0]),
    .empty       (empty[0])
  );

  small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(5), .PROG_FULL_THRESHOLD(31)) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .din         ({in1_ctrl, in1_data}),
    .wr_en       (in1_wr),
    .rd_en       (rd_en[1]),
    .dout        (fifo_dout[1]),
    .nearly_full (nearly_full[1]),
    .empty       (empty[1])
  );

  assign in0_rdy = !nearly_full[0];
  assign in1_rdy = !nearly_full[1];

  // Only between packets may the other input be picked; mid-packet we wait on the grantee.
  always_comb begin
    sel = gnt;
    if (state == IDLE && empty[gnt]) sel = !gnt;
  end

  assign out_wr               = !empty[sel] && out_rdy;
  assign {out_ctrl, out_data} = fifo_dout[sel];
  assign rd_en[0]             = out_wr && !sel;
  assign rd_en[1]             = out_wr && sel;

  assign ctrl_nz     = |out_ctrl;
  assign eop         = out_wr && (state == BODY) && ctrl_nz;
  assign weight      = gnt ? WEIGHT1_L : WEIGHT0_L;
  assign cnt_next    = {1'b0, cnt} + 9'd1;
  assign credit_done = (cnt_next >= {1'b0, weight});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      cnt   <= '0;
    end else if (out_wr) begin
      unique case (state)
        IDLE: begin
          state <= ctrl_nz ? HDR : BODY;
          if (sel != gnt) begin
            gnt <= sel;
            cnt <= '0;
          end
        end
        HDR: begin
          if (!ctrl_nz) state <= BODY;
        end
        BODY: begin
          if (ctrl_nz) begin
            state <= IDLE;
            if (credit_done) begin
              gnt <= !gnt;
              cnt <= '0;
            end else begin
              cnt <= cnt_next[7:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (eop) begin
      if (sel) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      else     pkt_cnt0 <= pkt_cnt0 + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Bench for wrr_pkt_arbiter: directed vector table, corner sequences, and randomized traffic
// checked against a packet-level WRR reference model.
`timescale 1ns/1ps
module tb_wrr_pkt_arbiter;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int W0 = 2;
  localparam int W1 = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in0_data = '0, in1_data = '0, out_data;
  logic [CW-1:0] in0_ctrl = '0, in1_ctrl = '0, out_ctrl;
  logic          in0_wr = 1'b0, in1_wr = 1'b0, out_wr;
  logic          in0_rdy, in1_rdy;
  logic          out_rdy = 1'b0;
`ifdef PKT_ARB_STATS_EN
  logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

  always #5 clk = ~clk;

  wrr_pkt_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .WEIGHT0(W0), .WEIGHT1(W1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in0_data (in0_data),
    .in0_ctrl (in0_ctrl),
    .in0_wr   (in0_wr),
    .in0_rdy  (in0_rdy),
    .in1_data (in1_data),
    .in1_ctrl (in1_ctrl),
    .in1_wr   (in1_wr),
    .in1_rdy  (in1_rdy),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy)
`ifdef PKT_ARB_STATS_EN
    ,
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    bit            first;
    bit            eop;
  } word_t;

  typedef struct {
    bit            wr;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    bit            first;
    bit            eop;
    bit            rdy;
    bit            exp_wr;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  word_t gq[2][$];
  word_t mq[2][$];
  int    src_log[$];
  bit    tag_first[2];
  bit    tag_eop[2];
  int    pkt_id = 0;

  bit    m_busy = 0;
  int    m_cur = 0, m_gnt = 0, m_cnt = 0;
  int    m_eop[2] = '{0, 0};

  // Packet-level reference: whole packets are granted by WRR rules, words leave in order.
  always @(negedge clk) begin
    int    es;
    bit    ew;
    word_t e;
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
      m_busy = 0;
      m_gnt  = 0;
      m_cnt  = 0;
      m_eop  = '{0, 0};
    end else begin
      es = m_busy ? m_cur : ((mq[m_gnt].size() != 0) ? m_gnt : 1 - m_gnt);
      ew = out_rdy && (mq[es].size() != 0);
      checks++;
      if (out_wr !== ew) begin
        errors++;
        $display("FAIL model_out_wr t=%0t got %b expected %b (src %0d)", $time, out_wr, ew, es);
      end
      if (out_wr && ew) begin
        e = mq[es].pop_front();
        checks++;
        if (out_data !== e.data || out_ctrl !== e.ctrl) begin
          errors++;
          $display("FAIL model_word t=%0t got %h/%h expected %h/%h (src %0d)",
                   $time, out_ctrl, out_data, e.ctrl, e.data, es);
        end
        if (!m_busy) begin
          if (es != m_gnt) begin
            m_gnt = es;
            m_cnt = 0;
          end
          m_busy = 1;
          m_cur  = es;
          src_log.push_back(es);
        end
        if (e.eop) begin
          m_busy = 0;
          m_eop[es]++;
          if (m_cnt + 1 >= ((m_gnt != 0) ? W1 : W0)) begin
            m_gnt = 1 - m_gnt;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
      end
      if (in0_wr) mq[0].push_back('{in0_data, in0_ctrl, tag_first[0], tag_eop[0]});
      if (in1_wr) mq[1].push_back('{in1_data, in1_ctrl, tag_first[1], tag_eop[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, bit wr, word_t w);
    if (p == 0) begin
      in0_wr = wr; in0_data = w.data; in0_ctrl = w.ctrl;
    end else begin
      in1_wr = wr; in1_data = w.data; in1_ctrl = w.ctrl;
    end
    tag_first[p] = w.first;
    tag_eop[p]   = w.eop;
  endtask

  // rmode: 0 ready, 1 toggle, 2 random, 3 stalled
  task automatic drive_cycle(int prob, int rmode);
    word_t w;
    word_t z;
    bit    rdy;
    z = '{default: 0};
    for (int p = 0; p < 2; p++) begin
      rdy = (p == 0) ? in0_rdy : in1_rdy;
      if (gq[p].size() != 0 && rdy && int'($urandom_range(99)) < prob) begin
        w = gq[p].pop_front();
        set_port(p, 1'b1, w);
      end else begin
        set_port(p, 1'b0, z);
      end
    end
    case (rmode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = !out_rdy;
      2:       out_rdy = 1'($urandom_range(1));
      default: out_rdy = 1'b0;
    endcase
  endtask

  task automatic gen_pkt(int p, int nhdr, int nbody);
    word_t w;
    int    n;
    n = nhdr + nbody + 1;
    for (int i = 0; i < n; i++) begin
      w.data = {8'(p), 24'(pkt_id), 16'(i), 16'($urandom)};
      if (i < nhdr)       w.ctrl = 8'(1 + $urandom_range(254));
      else if (i < n - 1) w.ctrl = 8'h00;
      else                w.ctrl = 8'h80 | 8'($urandom_range(127));
      w.first = (i == 0);
      w.eop   = (i == n - 1);
      gq[p].push_back(w);
    end
    pkt_id++;
  endtask

  task automatic wait_drain(int prob, int rmode, int budget, string name);
    int c;
    c = 0;
    while ((gq[0].size() != 0 || gq[1].size() != 0 || mq[0].size() != 0 || mq[1].size() != 0 ||
            m_busy || in0_wr || in1_wr) && c < budget) begin
      step();
      drive_cycle(prob, rmode);
      c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL drain_%s timeout after %0d cycles, queued %0d/%0d", name, c, mq[0].size(), mq[1].size());
    end
  endtask

  task automatic do_reset();
    word_t z;
    z = '{default: 0};
    step();
    reset = 1'b1;
    set_port(0, 1'b0, z);
    set_port(1, 1'b0, z);
    repeat (2) step();
    reset = 1'b0;
  endtask

  vec_t          vt[8];
  logic [CW-1:0] pctrl[6];
  int            exp_order[12];

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    word_t w;
    word_t z;
    int    acc;
    z = '{default: 0};

    pctrl = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 8; i++) begin
      vt[i].wr       = (i < 6);
      vt[i].ctrl     = (i < 6) ? pctrl[i] : 8'h00;
      vt[i].data     = 64'h100 + 64'(i);
      vt[i].first    = (i == 0);
      vt[i].eop      = (i == 5);
      vt[i].rdy      = 1'b1;
      vt[i].exp_wr   = (i >= 1 && i <= 6);
      vt[i].exp_ctrl = (i >= 1 && i <= 6) ? pctrl[i-1] : 8'h00;
      vt[i].exp_data = 64'h100 + 64'(i - 1);
    end
    exp_order = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};

    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_wr !== 1'b0 || in0_rdy !== 1'b1 || in1_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state out_wr=%b in0_rdy=%b in1_rdy=%b expected 0 1 1", out_wr, in0_rdy, in1_rdy);
    end

    // single packet on in0: six words on six consecutive cycles, one cycle after write
    for (int i = 0; i < 8; i++) begin
      step();
      w = '{vt[i].data, vt[i].ctrl, vt[i].first, vt[i].eop};
      set_port(0, vt[i].wr, w);
      set_port(1, 1'b0, z);
      out_rdy = vt[i].rdy;
      @(negedge clk);
      checks++;
      if (out_wr !== vt[i].exp_wr) begin
        errors++;
        $display("FAIL vec%0d_out_wr got %b expected %b", i, out_wr, vt[i].exp_wr);
      end
      if (vt[i].exp_wr) begin
        checks++;
        if (out_data !== vt[i].exp_data || out_ctrl !== vt[i].exp_ctrl) begin
          errors++;
          $display("FAIL vec%0d_word got %h/%h expected %h/%h", i, out_ctrl, out_data, vt[i].exp_ctrl, vt[i].exp_data);
        end
      end
    end

    // weighted order with both inputs backlogged
    do_reset();
    for (int k = 0; k < 6; k++) begin
      gen_pkt(0, 1, 2);
      gen_pkt(1, 1, 2);
    end
    src_log.delete();
    wait_drain(100, 0, 2000, "weighted");
    checks++;
    if (src_log.size() != 12) begin
      errors++;
      $display("FAIL weighted_count got %0d packets expected 12", src_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (src_log[k] != exp_order[k]) begin
          errors++;
          $display("FAIL weighted_order pkt%0d got src %0d expected %0d", k, src_log[k], exp_order[k]);
        end
      end
    end

    // only in1 active: queued packets leave with no idle gap
    for (int k = 0; k < 4; k++) gen_pkt(1, 1, 2);
    src_log.delete();
    while (gq[1].size() != 0) begin
      step();
      drive_cycle(100, 3);
    end
    for (int i = 0; i < 18; i++) begin
      step();
      drive_cycle(100, 0);
      @(negedge clk);
      checks++;
      if (out_wr !== 1'(i < 16)) begin
        errors++;
        $display("FAIL b2b_cycle%0d out_wr got %b expected %b", i, out_wr, 1'(i < 16));
      end
    end
    checks++;
    if (src_log.size() != 4 || src_log.sum() != 4) begin
      errors++;
      $display("FAIL b2b_src got %0d packets sum %0d expected 4 packets all from in1", src_log.size(), src_log.sum());
    end

    // backpressure: in0_rdy drops once 31 words are held
    gen_pkt(0, 1, 29);
    gen_pkt(0, 1, 7);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      drive_cycle(100, 3);
      if (in0_wr) acc++;
    end
    @(negedge clk);
    checks++;
    if (acc != 31 || in0_rdy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure accepted %0d in0_rdy=%b expected 31 and 0", acc, in0_rdy);
    end
    wait_drain(100, 0, 2000, "backpressure");

    // reset on the 3rd word of an in1 packet
    gen_pkt(1, 2, 3);
    for (int i = 0; i < 6; i++) begin
      step();
      drive_cycle(100, 3);
    end
    step(); drive_cycle(100, 0);
    step(); drive_cycle(100, 0);
    step(); drive_cycle(100, 0); reset = 1'b1;
    step(); reset = 1'b0; drive_cycle(100, 0);
    @(negedge clk);
    checks++;
    if (out_wr !== 1'b0 || in0_rdy !== 1'b1 || in1_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midpkt_reset out_wr=%b in0_rdy=%b in1_rdy=%b expected 0 1 1", out_wr, in0_rdy, in1_rdy);
    end
`ifdef PKT_ARB_STATS_EN
    checks++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
      errors++;
      $display("FAIL midpkt_reset_stats got %0d %0d expected 0 0", pkt_cnt0, pkt_cnt1);
    end
`endif
    gen_pkt(0, 1, 2);
    gen_pkt(1, 1, 2);
    src_log.delete();
    wait_drain(100, 0, 500, "post_reset");
    checks++;
    if (src_log.size() != 2 || src_log[0] != 0) begin
      errors++;
      $display("FAIL post_reset_gnt first src %0d of %0d packets expected src 0", (src_log.size() != 0) ? src_log[0] : -1, src_log.size());
    end

    // randomized traffic: toggling ready, then random ready
    for (int k = 0; k < 20; k++) begin
      gen_pkt(0, $urandom_range(2), 1 + $urandom_range(3));
      gen_pkt(1, $urandom_range(2), 1 + $urandom_range(3));
    end
    wait_drain(80, 1, 5000, "toggle");
    for (int k = 0; k < 30; k++) begin
      gen_pkt(0, $urandom_range(2), 1 + $urandom_range(4));
      gen_pkt(1, $urandom_range(2), 1 + $urandom_range(4));
    end
    wait_drain(60, 2, 8000, "random");
`ifdef PKT_ARB_STATS_EN
    checks++;
    if (pkt_cnt0 !== 32'(m_eop[0]) || pkt_cnt1 !== 32'(m_eop[1])) begin
      errors++;
      $display("FAIL stats got %0d %0d expected %0d %0d", pkt_cnt0, pkt_cnt1, m_eop[0], m_eop[1]);
    end
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
